// File: rtl/hangman_pkg.sv
// Shared hangman types and constants: host FSM states, ASCII letter bounds
// and the default word length.
package hangman_pkg;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        ARM   = 2'd1,
        PLAY  = 2'd2
    } host_state_t;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_LA = 8'h61;
    localparam logic [7:0] ASCII_LZ = 8'h7A;
    localparam logic [7:0] CASE_OFS = 8'h20;

    localparam int DEFAULT_WORD_LEN = 5;

endpackage

// File: rtl/char_normalize.sv
// Letter classifier: flags A-Z / a-z, folds to uppercase and gives the
// alphabet index used for the guessed-letter bitmap.
module char_normalize
    import hangman_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       valid,
    output logic [7:0] upper,
    output logic [4:0] idx
);

    logic [7:0] diff;

    always_comb begin
        valid = 1'b0;
        upper = 8'h00;
        idx   = 5'd0;
        diff  = 8'h00;
        if (char_in >= ASCII_A && char_in <= ASCII_Z) begin
            valid = 1'b1;
            upper = char_in;
        end else if (char_in >= ASCII_LA && char_in <= ASCII_LZ) begin
            valid = 1'b1;
            upper = char_in - CASE_OFS;
        end
        // Invalid characters report index 0 so the bitmap lookup stays in range.
        if (valid) begin
            diff = upper - ASCII_A;
            idx  = diff[4:0];
        end
    end

endmodule

// File: rtl/host_word_entry.sv
// Host front end of the hangman datapath: builds the secret word from keypad
// characters, arms the game, then filters and forwards player guesses.
module host_word_entry #(
    parameter int WORD_LEN = hangman_pkg::DEFAULT_WORD_LEN
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  key_strobe,
    input  logic [7:0]            key_char,
    input  logic                  key_back,
    input  logic                  key_enter,
    input  logic                  guess_strobe,
    input  logic [7:0]            guess_char,
    input  logic                  game_rdy,
    input  logic                  game_done,
    output logic [8*WORD_LEN-1:0] setWord,
    output logic                  toggle_state,
    output logic [7:0]            guess,
    output logic [2:0]            entry_count,
    output logic                  host_busy,
    output logic                  reject
);

    import hangman_pkg::*;

    localparam logic [2:0] FULL_CNT = 3'(WORD_LEN);

    host_state_t           state_q, state_d;
    logic [8*WORD_LEN-1:0] word_q, word_d;
    logic [2:0]            count_q, count_d;
    logic [7:0]            guess_q, guess_d;
    logic [25:0]           used_q, used_d;
    logic                  toggle_q, toggle_d;
    logic                  reject_q, reject_d;

    logic       key_valid, guess_valid;
    logic [7:0] key_upper, guess_upper;
    logic [4:0] key_idx, guess_idx;
    logic       any_key;

    char_normalize u_key_norm (
        .char_in (key_char),
        .valid   (key_valid),
        .upper   (key_upper),
        .idx     (key_idx)
    );

    char_normalize u_guess_norm (
        .char_in (guess_char),
        .valid   (guess_valid),
        .upper   (guess_upper),
        .idx     (guess_idx)
    );

    assign any_key = key_strobe | key_back | key_enter;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        count_d  = count_q;
        guess_d  = guess_q;
        used_d   = used_q;
        toggle_d = 1'b0;
        reject_d = 1'b0;

        unique case (state_q)
            ENTRY: begin
                // Enter beats back beats strobe; the losing pulses are dropped.
                if (key_enter) begin
                    if (count_q == FULL_CNT) state_d = ARM;
                    else                     reject_d = 1'b1;
                end else if (key_back) begin
                    if (count_q != 3'd0) begin
                        word_d  = word_q >> 8;
                        count_d = count_q - 3'd1;
                    end
                end else if (key_strobe) begin
                    if (key_valid && count_q < FULL_CNT) begin
                        word_d  = {word_q[8*WORD_LEN-9:0], key_upper};
                        count_d = count_q + 3'd1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                if (guess_strobe) reject_d = 1'b1;
            end

            ARM: begin
                if (any_key || guess_strobe) reject_d = 1'b1;
                if (game_rdy) begin
                    toggle_d = 1'b1;
                    used_d   = '0;
                    state_d  = PLAY;
                end
            end

            PLAY: begin
                if (any_key) reject_d = 1'b1;
                if (game_done) begin
                    state_d = ENTRY;
                    word_d  = '0;
                    count_d = 3'd0;
                    guess_d = 8'h00;
                    used_d  = '0;
                end else if (guess_strobe) begin
                    if (game_rdy && guess_valid && !used_q[guess_idx]) begin
                        guess_d           = guess_upper;
                        used_d[guess_idx] = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            default: state_d = ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ENTRY;
            word_q   <= '0;
            count_q  <= 3'd0;
            guess_q  <= 8'h00;
            used_q   <= '0;
            toggle_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            count_q  <= count_d;
            guess_q  <= guess_d;
            used_q   <= used_d;
            toggle_q <= toggle_d;
            reject_q <= reject_d;
        end
    end

    // key_idx is only meaningful to the guess path; keep it referenced.
    logic unused_key_idx;
    assign unused_key_idx = ^key_idx;

    assign setWord      = word_q;
    assign entry_count  = count_q;
    assign guess        = guess_q;
    assign toggle_state = toggle_q;
    assign reject       = reject_q;
    assign host_busy    = (state_q != ENTRY);

endmodule

// File: doc/host_word_entry.md
# host_word_entry

Host-side front end of the hangman datapath. Assembles the secret word from keypad characters, presents it as `setWord`, and fires the one-cycle `toggle_state` that starts a round. During play it validates, normalises and forwards player guesses onto `guess`. It drives the word, start and guess inputs that the game-logic block consumes, and watches that block's `game_rdy`.

## Interface
- `WORD_LEN`, 5: characters per word; `setWord` width is `8*WORD_LEN`.
- `clk` input 1: system clock, rising edge.
- `nRst` input 1: asynchronous active-low reset.
- `key_strobe` input 1: one-cycle pulse; `key_char` valid (host keypad).
- `key_char` input 8: ASCII character from host.
- `key_back` input 1: one-cycle pulse; delete last entered character.
- `key_enter` input 1: one-cycle pulse; confirm word.
- `guess_strobe` input 1: one-cycle pulse; `guess_char` valid (player).
- `guess_char` input 8: ASCII guess from player.
- `game_rdy` input 1: game logic is idle and accepts a start or a new guess.
- `game_done` input 1: one-cycle pulse from game logic on win or lose (`green | red`).
- `setWord` output 8*WORD_LEN: entered word, first character in bits [8*WORD_LEN-1 -: 8].
- `toggle_state` output 1: one-cycle start pulse to game logic.
- `guess` output 8: current uppercase guess, held until the next accepted guess.
- `entry_count` output 3: characters currently entered (0..WORD_LEN).
- `host_busy` output 1: high whenever state ≠ ENTRY.
- `reject` output 1: one-cycle pulse when an input is refused.

## Operation
- Character validity: 0x41–0x5A accepted as is. 0x61–0x7A accepted after subtracting 0x20. Anything else is invalid.
- **ENTRY** (reset state):
  - Valid `key_strobe` with `entry_count` < WORD_LEN: `setWord <= {setWord[8*WORD_LEN-9:0], char}` and `entry_count` increments. The first typed character ends in the MSB byte once the word is full.
  - `key_strobe` with an invalid char, or with `entry_count` == WORD_LEN: `reject`; no other change.
  - `key_back` with `entry_count` > 0: `setWord` shifts right 8 with zero fill; count decrements. With count 0: no-op, no reject.
  - `key_enter` with count == WORD_LEN: go to ARM. Otherwise: `reject`.
  - Simultaneous pulses: priority enter > back > strobe. Only the winner acts; losers are dropped silently.
  - `guess_strobe` in ENTRY: `reject`.
- **ARM**:
  - `setWord` is frozen.
  - When `game_rdy` = 1: `toggle_state` is 1 for exactly the next cycle, and the state becomes PLAY on the same edge.
  - While `game_rdy` = 0: wait indefinitely.
  - All key and guess pulses: `reject`.
- **PLAY**:
  - `setWord` is frozen.
  - A 26-bit `used` bitmap, indexed by letter − 'A', is cleared on entry to PLAY.
  - `guess_strobe` is accepted only if `game_rdy` = 1, the char is valid, and its `used` bit is clear. Then `guess <= upper(char)` and the `used` bit is set.
  - Otherwise `reject`, and `guess` is unchanged. Repeated letters are never re-presented, so `guess` changes on every accepted guess.
  - Key pulses: `reject`.
  - `game_done`: go to ENTRY. Clear `setWord`, `entry_count`, `guess` and `used`. `game_done` has priority over a simultaneous `guess_strobe`; that guess is dropped without reject.
- `game_done` outside PLAY is ignored.

## Timing
- All outputs are registered and change one cycle after the sampled input edge. No combinational input-to-output path.
- Reset values:
  - `setWord`, `guess`, `entry_count`, `used`: 0.
  - `toggle_state`, `reject`, `host_busy`: 0.
  - State: ENTRY.
- `reject` and `toggle_state` are never high for more than one consecutive cycle per event.
- `nRst` low mid-entry or mid-play: immediate return to reset values, no pulse emitted.
- `entry_count` width: 3 bits, sufficient for WORD_LEN ≤ 7. Increment saturates at WORD_LEN; decrement floors at 0.

## Structure
- Shared package `hangman_pkg`:
  - enum `host_state_t` {ENTRY, ARM, PLAY}.
  - constants `ASCII_A`=8'h41, `ASCII_Z`=8'h5A, `ASCII_LA`=8'h61, `ASCII_LZ`=8'h7A, `CASE_OFS`=8'h20.
  - `WORD_LEN` default.
- One sub-module, `char_normalize`, shared by the key path and the guess path:
  - combinational; input 8-bit char.
  - outputs `valid`, `upper[7:0]`, `idx[4:0]`.

## Test plan
- Reset, key "c","a","t","s","e", enter, `game_rdy`=1 → `setWord`=40'h4341545345, `entry_count`=5, `toggle_state` one-cycle pulse, `host_busy`=1.
- Enter "AB", back, "Z" → `setWord`=40'h000000415A, count=2. Enter at count 2 → `reject` pulse, state stays ENTRY.
- Key '3' (0x33) → `reject`. Six valid keys → sixth rejected, `setWord` keeps the first five.
- ARM with `game_rdy`=0 for 10 cycles → no `toggle_state`. Raise `game_rdy` → pulse one cycle later.
- PLAY: guess 'e' → `guess`=8'h45. Guess 'E' again → `reject`, `guess` unchanged. Guess while `game_rdy`=0 → `reject`.
- `game_done` same cycle as `guess_strobe` → ENTRY, all cleared, no reject. Assert `nRst` mid-PLAY → all outputs 0.
